noc_onehot_decode: RTL and testbench
====================================

NOC_ONEHOT_DECODE -- requirements
Module: noc_onehot_decode

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning the one-hot input width; legal range 1..64.
REQ-002 SHALL have derived localparam IDX_W = max(1, ceil(log2(WIDTH))), meaning the index width; it is not overridable.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  upstream word valid.
REQ-006 SHALL have port in_ready  output  1  block can accept; driven from a register.
REQ-007 SHALL have port in_onehot  input  WIDTH  word to decode, expected one-hot.
REQ-008 SHALL have port out_valid  output  1  decoded word valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts.
REQ-010 SHALL have port out_index  output  IDX_W  binary index of the decoded bit.
REQ-011 SHALL have port out_zero  output  1  source word had no bit set.
REQ-012 SHALL have port out_multi  output  1  source word had more than one bit set.
REQ-013 SHALL have port err_cnt  output  8  saturating count of malformed words accepted.

Function
REQ-014 SHALL accept a word on a cycle where in_valid=1 and in_ready=1.
REQ-015 SHALL emit a word on a cycle where out_valid=1 and out_ready=1.
REQ-016 SHALL decode out_index as the position of the lowest set bit of in_onehot, which matches the priority one-hot semantics used in the fabric.
REQ-017 SHALL, for a word with no bit set, produce out_index=0 and out_zero=1.
REQ-018 SHALL, for a word with two or more bits set, produce out_index equal to the lowest set bit and out_multi=1.
REQ-019 SHALL never assert out_zero and out_multi together.
REQ-020 SHALL hold one output register and one skid register (2-entry buffer); both store the decoded index and flags, not the raw word.
REQ-021 SHALL give a latency of 1 cycle: a word accepted in cycle N into an empty block is presented on out_* in cycle N+1.
REQ-022 SHALL sustain a throughput of 1 word per cycle while out_ready=1.
REQ-023 SHALL drive in_ready = NOT skid_valid, registered; there is no combinational path from out_ready to in_ready.
REQ-024 SHALL, when the output register is empty or being emitted this cycle, load it from the skid register if the skid is occupied, else from an accepted input.
REQ-025 SHALL, when the output register is occupied and not being emitted, write an accepted input into the skid register.
REQ-026 SHALL preserve word order; no word is dropped or duplicated.
REQ-027 SHALL hold out_index, out_zero and out_multi stable while out_valid=1 and out_ready=0.
REQ-028 SHALL increment err_cnt by 1 on each accepted word with zero or multiple bits set, counted at acceptance, not emission.
REQ-029 SHALL saturate err_cnt at 255; there is no wrap.
REQ-030 SHALL, for WIDTH=1, give out_index=0 always, with out_zero = NOT in_onehot[0] and out_multi=0.
REQ-031 SHALL ignore in_onehot when in_valid=0; such cycles cause no state or counter change.
REQ-032 SHALL, on simultaneous accept and emit with the skid empty, replace the output register contents in the same cycle, leaving out_valid=1 and the skid unused.

Reset
REQ-033 SHALL, on rst_n=0 sampled at a clk edge, clear both buffer entries, out_valid=0, out_index=0, out_zero=0, out_multi=0 and err_cnt=0.
REQ-034 SHALL drive in_ready=0 during reset and 1 in the first cycle after reset release.
REQ-035 SHALL, on reset asserted mid-operation, discard all buffered words; no word is presented after release unless it is newly accepted.

Verification
REQ-036 SHALL cover: WIDTH=8, in_onehot=8'b0010_0000 accepted, out_ready=1 -> next cycle out_index=5, out_zero=0, out_multi=0, err_cnt=0.
REQ-037 SHALL cover: WIDTH=8, inputs 8'h00 then 8'b0100_1100 -> out_index=0 with out_zero=1, then out_index=2 with out_multi=1; err_cnt=2.
REQ-038 SHALL cover: continuous valid input with out_ready held 0 for 3 cycles -> exactly 2 words buffered, in_ready=0 from the cycle after the second accept; on out_ready=1 the words drain in order and in_ready returns to 1 one cycle later.
REQ-039 SHALL cover: 300 consecutive 8'h00 words accepted -> err_cnt stops at 255.
REQ-040 SHALL cover: rst_n=0 for one cycle with both entries full -> out_valid=0, err_cnt=0, in_ready=0 during reset, in_ready=1 the cycle after.
REQ-041 SHALL cover: randomized valid/ready with WIDTH in {1, 5, 8} -> scoreboard shows out_index equal to the lowest set bit, flags correct, order preserved and no loss.

Source files
------------

// File: rtl/noc_onehot_decode.sv
// noc_onehot_decode
// Priority one-hot decoder with a two-entry elastic buffer on its output side.
// The lowest set bit of an accepted word is converted to a binary index, and
// each word is tagged with "no bit set" / "several bits set" flags. Only the
// decoded record is stored; the raw word is never kept. in_ready comes
// straight from a flop and depends only on whether the skid entry will be
// occupied, so out_ready has no combinational path to in_ready. A saturating
// counter tallies malformed words at the moment they are accepted.
module noc_onehot_decode #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_onehot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic             out_zero,
    output logic             out_multi,
    output logic [7:0]       err_cnt
);

    // Decoded record held in the output and skid entries
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             zero;
        logic             multi;
    } dec_t;

    // Position of the lowest set bit; zero when no bit is set
    function automatic logic [IDX_W-1:0] f_lowest_index(input logic [WIDTH-1:0] word);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = {IDX_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            idx   = (word[i] && !found) ? IDX_W'(i) : idx;
            found = found | word[i];
        end
        return idx;
    endfunction

    // Population count of the word (WIDTH is at most 64, so 7 bits suffice)
    function automatic logic [6:0] f_set_count(input logic [WIDTH-1:0] word);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt = cnt + {6'd0, word[i]};
        end
        return cnt;
    endfunction

    // Full decode of one input word into the stored record
    function automatic dec_t f_decode(input logic [WIDTH-1:0] word);
        dec_t       d;
        logic [6:0] cnt;
        cnt     = f_set_count(word);
        d.idx   = f_lowest_index(word);
        d.zero  = (cnt == 7'd0);
        d.multi = (cnt > 7'd1);
        return d;
    endfunction

    // State registers
    dec_t       r_out;
    logic       r_out_valid;
    dec_t       r_skid;
    logic       r_skid_valid;
    logic       r_in_ready;
    logic [7:0] r_err_cnt;

    // Next-state and handshake wires
    logic       w_accept;
    logic       w_emit;
    dec_t       w_dec;
    logic       w_malformed;
    dec_t       w_out_nxt;
    logic       w_out_valid_nxt;
    dec_t       w_skid_nxt;
    logic       w_skid_valid_nxt;
    logic [7:0] w_err_cnt_nxt;

    assign w_accept    = in_valid & r_in_ready;
    assign w_emit      = r_out_valid & out_ready;
    assign w_dec       = f_decode(in_onehot);
    assign w_malformed = w_dec.zero | w_dec.multi;

    // Buffer steering: refill the output entry from skid first, else from input
    always_comb begin
        w_out_nxt        = r_out;
        w_out_valid_nxt  = r_out_valid;
        w_skid_nxt       = r_skid;
        w_skid_valid_nxt = r_skid_valid;
        if (!r_out_valid || w_emit) begin
            // Output entry is free (or leaving this cycle); the skid entry is
            // older than anything arriving now, so it goes first. in_ready is
            // low whenever skid is occupied, so no input can collide here.
            if (r_skid_valid) begin
                w_out_nxt        = r_skid;
                w_out_valid_nxt  = 1'b1;
                w_skid_valid_nxt = 1'b0;
            end else if (w_accept) begin
                w_out_nxt       = w_dec;
                w_out_valid_nxt = 1'b1;
            end else begin
                w_out_valid_nxt = 1'b0;
            end
        end else begin
            // Output entry is stalled; park a newly accepted word in skid
            if (w_accept) begin
                w_skid_nxt       = w_dec;
                w_skid_valid_nxt = 1'b1;
            end else begin
                w_skid_valid_nxt = r_skid_valid;
            end
        end
    end

    // Malformed-word counter, bumped on acceptance and held at 255
    always_comb begin
        w_err_cnt_nxt = r_err_cnt;
        if (w_accept && w_malformed && (r_err_cnt != 8'hFF)) begin
            w_err_cnt_nxt = r_err_cnt + 8'd1;
        end else begin
            w_err_cnt_nxt = r_err_cnt;
        end
    end

    // State update with synchronous active-low reset that flushes both entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out        <= '{idx: {IDX_W{1'b0}}, zero: 1'b0, multi: 1'b0};
            r_out_valid  <= 1'b0;
            r_skid       <= '{idx: {IDX_W{1'b0}}, zero: 1'b0, multi: 1'b0};
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_out        <= w_out_nxt;
            r_out_valid  <= w_out_valid_nxt;
            r_skid       <= w_skid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_index = r_out.idx;
    assign out_zero  = r_out.zero;
    assign out_multi = r_out.multi;
    assign err_cnt   = r_err_cnt;

endmodule

// Property checker for noc_onehot_decode output behaviour
module noc_onehot_decode_chk #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input logic             clk,
    input logic             rst_n,
    input logic             out_valid,
    input logic             out_ready,
    input logic [IDX_W-1:0] out_index,
    input logic             out_zero,
    input logic             out_multi,
    input logic [7:0]       err_cnt
);

    // The two malformation flags describe disjoint cases
    a_flags_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(out_zero && out_multi));

    // A stalled output word must not change under the consumer
    a_hold_on_stall: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=>
            (out_valid && $stable(out_index) && $stable(out_zero) && $stable(out_multi)));

    // The error counter sticks at its ceiling
    a_err_saturates: assert property (@(posedge clk) disable iff (!rst_n)
        (err_cnt == 8'hFF) |=> (err_cnt == 8'hFF));

endmodule

// File: tb/tb_noc_onehot_decode.sv
// Testbench for noc_onehot_decode: table-driven and hand-written directed
// sequences on an 8-bit instance, then randomized handshakes on 1-, 5- and
// 8-bit instances checked against an arithmetic reference model.
module tb_noc_onehot_decode;

    logic clk;
    logic rst_n;

    // WIDTH=8 instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, out_zero8, out_multi8;
    logic [7:0] in_onehot8;
    logic [2:0] out_index8;
    logic [7:0] err_cnt8;
    // WIDTH=5 instance
    logic       in_valid5, in_ready5, out_valid5, out_ready5, out_zero5, out_multi5;
    logic [4:0] in_onehot5;
    logic [2:0] out_index5;
    logic [7:0] err_cnt5;
    // WIDTH=1 instance
    logic       in_valid1, in_ready1, out_valid1, out_ready1, out_zero1, out_multi1;
    logic [0:0] in_onehot1;
    logic [0:0] out_index1;
    logic [7:0] err_cnt1;

    int checks = 0;
    int errors = 0;

    noc_onehot_decode #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_onehot(in_onehot8), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_index(out_index8), .out_zero(out_zero8), .out_multi(out_multi8),
        .err_cnt(err_cnt8));

    noc_onehot_decode #(.WIDTH(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
        .in_onehot(in_onehot5), .out_valid(out_valid5), .out_ready(out_ready5),
        .out_index(out_index5), .out_zero(out_zero5), .out_multi(out_multi5),
        .err_cnt(err_cnt5));

    noc_onehot_decode #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_onehot(in_onehot1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_index(out_index1), .out_zero(out_zero1), .out_multi(out_multi1),
        .err_cnt(err_cnt1));

    noc_onehot_decode_chk #(.WIDTH(8)) u_chk8 (
        .clk(clk), .rst_n(rst_n), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_index(out_index8), .out_zero(out_zero8), .out_multi(out_multi8),
        .err_cnt(err_cnt8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: isolate the lowest set bit with w & -w, take its log2.
    // Result packs {zero, multi, idx[5:0]}.
    function automatic logic [7:0] ref_dec(input logic [63:0] w);
        logic [63:0] iso;
        logic [5:0]  idx;
        logic        zero, multi;
        iso   = w & (~w + 64'd1);
        zero  = (w == 64'd0);
        multi = ((w & (w - 64'd1)) != 64'd0);
        idx   = zero ? 6'd0 : 6'($clog2(iso));
        return {zero, multi, idx};
    endfunction

    function automatic logic [63:0] rand_word(input int w);
        logic [63:0] mask;
        int sel;
        mask = (64'd1 << w) - 64'd1;
        sel  = $urandom_range(0, 3);
        if (sel == 0) return 64'd0;
        else if (sel == 3) return {$urandom, $urandom} & mask;
        else return 64'd1 << $urandom_range(0, w - 1);
    endfunction

    // Scoreboards for the randomized phase
    bit         mon_en = 1'b0;
    logic [7:0] q8[$], q5[$], q1[$];
    int         exp_err8, exp_err5, exp_err1;

    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) chk("w8_spurious_out", 64'd1, 64'd0);
                else begin
                    e = q8.pop_front();
                    chk("w8_index", 64'(out_index8), 64'(e[5:0]));
                    chk("w8_zero", 64'(out_zero8), 64'(e[7]));
                    chk("w8_multi", 64'(out_multi8), 64'(e[6]));
                end
            end
            chk("w8_err_cnt", 64'(err_cnt8), 64'(exp_err8));
            if (in_valid8 && in_ready8) begin
                e = ref_dec(64'(in_onehot8));
                q8.push_back(e);
                if ((e[7] || e[6]) && exp_err8 < 255) exp_err8++;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            if (out_valid5 && out_ready5) begin
                if (q5.size() == 0) chk("w5_spurious_out", 64'd1, 64'd0);
                else begin
                    e = q5.pop_front();
                    chk("w5_index", 64'(out_index5), 64'(e[5:0]));
                    chk("w5_zero", 64'(out_zero5), 64'(e[7]));
                    chk("w5_multi", 64'(out_multi5), 64'(e[6]));
                end
            end
            chk("w5_err_cnt", 64'(err_cnt5), 64'(exp_err5));
            if (in_valid5 && in_ready5) begin
                e = ref_dec(64'(in_onehot5));
                q5.push_back(e);
                if ((e[7] || e[6]) && exp_err5 < 255) exp_err5++;
            end
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        if (mon_en) begin
            if (out_valid1 && out_ready1) begin
                if (q1.size() == 0) chk("w1_spurious_out", 64'd1, 64'd0);
                else begin
                    e = q1.pop_front();
                    chk("w1_index", 64'(out_index1), 64'(e[5:0]));
                    chk("w1_zero", 64'(out_zero1), 64'(e[7]));
                    chk("w1_multi", 64'(out_multi1), 64'(e[6]));
                end
            end
            chk("w1_err_cnt", 64'(err_cnt1), 64'(exp_err1));
            if (in_valid1 && in_ready1) begin
                e = ref_dec(64'(in_onehot1));
                q1.push_back(e);
                if ((e[7] || e[6]) && exp_err1 < 255) exp_err1++;
            end
        end
    end

    typedef struct {
        logic [7:0] word;
        logic [2:0] idx;
        logic       zero;
        logic       multi;
        logic [7:0] err;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drained;
        vecs[0] = '{8'h20, 3'd5, 1'b0, 1'b0, 8'd0};
        vecs[1] = '{8'h00, 3'd0, 1'b1, 1'b0, 8'd1};
        vecs[2] = '{8'h4C, 3'd2, 1'b0, 1'b1, 8'd2};
        vecs[3] = '{8'h01, 3'd0, 1'b0, 1'b0, 8'd2};
        vecs[4] = '{8'h80, 3'd7, 1'b0, 1'b0, 8'd2};
        vecs[5] = '{8'hFF, 3'd0, 1'b0, 1'b1, 8'd3};
        vecs[6] = '{8'h18, 3'd3, 1'b0, 1'b1, 8'd4};
        vecs[7] = '{8'h02, 3'd1, 1'b0, 1'b0, 8'd4};

        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; in_onehot8 = 8'h00;
        in_valid5 = 1'b0; out_ready5 = 1'b0; in_onehot5 = 5'h00;
        in_valid1 = 1'b0; out_ready1 = 1'b0; in_onehot1 = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready8), 64'd0);
        chk("rst_out_valid", 64'(out_valid8), 64'd0);
        chk("rst_out_index", 64'(out_index8), 64'd0);
        chk("rst_out_zero", 64'(out_zero8), 64'd0);
        chk("rst_out_multi", 64'(out_multi8), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt8), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", 64'(in_ready8), 64'd1);

        // Table: back-to-back words with out_ready high, one-cycle latency
        out_ready8 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tbl_in_ready", 64'(in_ready8), 64'd1);
            in_valid8  = 1'b1;
            in_onehot8 = vecs[i].word;
            tick();
            in_valid8 = 1'b0;
            chk("tbl_out_valid", 64'(out_valid8), 64'd1);
            chk("tbl_index", 64'(out_index8), 64'(vecs[i].idx));
            chk("tbl_zero", 64'(out_zero8), 64'(vecs[i].zero));
            chk("tbl_multi", 64'(out_multi8), 64'(vecs[i].multi));
            chk("tbl_err_cnt", 64'(err_cnt8), 64'(vecs[i].err));
        end
        tick();
        chk("tbl_drained", 64'(out_valid8), 64'd0);

        // Stall with continuous valid: two words buffered, then drain in order
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        in_onehot8 = 8'h01;
        tick();
        chk("stall_a_valid", 64'(out_valid8), 64'd1);
        chk("stall_a_index", 64'(out_index8), 64'd0);
        chk("stall_ready1", 64'(in_ready8), 64'd1);
        in_onehot8 = 8'h02;
        tick();
        chk("stall_ready2", 64'(in_ready8), 64'd0);
        chk("stall_hold1", 64'(out_index8), 64'd0);
        in_onehot8 = 8'h04;
        tick();
        chk("stall_ready3", 64'(in_ready8), 64'd0);
        chk("stall_hold2", 64'(out_index8), 64'd0);
        chk("stall_hold_valid", 64'(out_valid8), 64'd1);
        out_ready8 = 1'b1;
        tick();
        chk("drain_b_index", 64'(out_index8), 64'd1);
        chk("drain_b_valid", 64'(out_valid8), 64'd1);
        chk("drain_ready_back", 64'(in_ready8), 64'd1);
        tick();
        in_valid8 = 1'b0;
        chk("drain_c_index", 64'(out_index8), 64'd2);
        chk("drain_c_valid", 64'(out_valid8), 64'd1);
        tick();
        chk("drain_empty", 64'(out_valid8), 64'd0);
        chk("drain_err_cnt", 64'(err_cnt8), 64'd4);

        // Reset with both entries full
        out_ready8 = 1'b0;
        in_valid8  = 1'b1;
        in_onehot8 = 8'h00;
        tick();
        in_onehot8 = 8'h03;
        tick();
        in_valid8 = 1'b0;
        chk("full_err_cnt", 64'(err_cnt8), 64'd6);
        chk("full_in_ready", 64'(in_ready8), 64'd0);
        rst_n = 1'b0;
        tick();
        chk("midrst_out_valid", 64'(out_valid8), 64'd0);
        chk("midrst_err_cnt", 64'(err_cnt8), 64'd0);
        chk("midrst_in_ready", 64'(in_ready8), 64'd0);
        rst_n      = 1'b1;
        out_ready8 = 1'b1;
        tick();
        chk("midrel_in_ready", 64'(in_ready8), 64'd1);
        chk("midrel_out_valid", 64'(out_valid8), 64'd0);
        tick();
        chk("midrel_no_ghost", 64'(out_valid8), 64'd0);

        // 300 consecutive empty words: counter saturates at 255
        in_valid8  = 1'b1;
        in_onehot8 = 8'h00;
        for (int k = 1; k <= 300; k++) begin
            tick();
            chk("sat_err_cnt", 64'(err_cnt8), 64'((k > 255) ? 255 : k));
        end
        in_valid8 = 1'b0;
        tick();
        chk("sat_idle_hold", 64'(err_cnt8), 64'd255);

        // Randomized phase on all three widths
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        q8.delete(); q5.delete(); q1.delete();
        exp_err8 = 0; exp_err5 = 0; exp_err1 = 0;
        mon_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            in_valid8  = ($urandom_range(0, 9) < 7);
            out_ready8 = ($urandom_range(0, 9) < 6);
            in_onehot8 = 8'(rand_word(8));
            in_valid5  = ($urandom_range(0, 9) < 7);
            out_ready5 = ($urandom_range(0, 9) < 5);
            in_onehot5 = 5'(rand_word(5));
            in_valid1  = ($urandom_range(0, 9) < 6);
            out_ready1 = ($urandom_range(0, 9) < 7);
            in_onehot1 = 1'(rand_word(1));
            tick();
        end
        in_valid8 = 1'b0; in_valid5 = 1'b0; in_valid1 = 1'b0;
        out_ready8 = 1'b1; out_ready5 = 1'b1; out_ready1 = 1'b1;
        drained = 0;
        for (int c = 0; c < 20 && drained == 0; c++) begin
            tick();
            if (q8.size() == 0 && q5.size() == 0 && q1.size() == 0) drained = 1;
        end
        tick();
        chk("rand_q8_empty", 64'(q8.size()), 64'd0);
        chk("rand_q5_empty", 64'(q5.size()), 64'd0);
        chk("rand_q1_empty", 64'(q1.size()), 64'd0);
        chk("rand_out8_idle", 64'(out_valid8), 64'd0);
        mon_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
